// File: rtl/spi_mem_bridge_if.sv
// Byte-wide memory bus between the core and the SPI SRAM bridge.
// The core holds a request level until it sees bus_wait low.
interface spi_mem_bridge_if;
   logic [15:0] bus_address_in;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic        bus_read;
   logic        bus_write;
   logic        bus_wait;

   modport master (
      output bus_address_in, bus_data_in, bus_read, bus_write,
      input  bus_data_out, bus_wait
   );

   modport slave (
      input  bus_address_in, bus_data_in, bus_read, bus_write,
      output bus_data_out, bus_wait
   );
endinterface

// File: rtl/spi_mem_bridge.sv
// Converts single-byte bus reads/writes into SPI mode-0 transactions to a 23LC512-style SRAM.
// bus_wait stalls the core until the 32-bit frame completes; read data is held until the next read.
module spi_mem_bridge #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_mem_bridge_if.slave   bus,
   output logic              spi_sck,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   typedef enum logic [1:0] {StIdle, StShift, StFinish, StDone} state_e;

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic        done_q, done_d;
   logic        sck_q, sck_d;
   logic        cs_n_q, cs_n_d;
   logic [31:0] tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic        op_write_q, op_write_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        req;

   assign req              = bus.bus_read | bus.bus_write;
   assign bus.bus_wait     = req & ~done_q;
   assign bus.bus_data_out = rdata_q;
   assign spi_sck          = sck_q;
   assign spi_cs_n         = cs_n_q;
   assign spi_mosi         = (state_q == StShift) & tx_q[31];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         done_q     <= 1'b0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         op_write_q <= 1'b0;
         rdata_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         op_write_q <= op_write_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      op_write_d = op_write_q;
      rdata_d    = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               // Write wins when both request levels are high.
               op_write_d = bus.bus_write;
               tx_d       = {bus.bus_write ? 8'h02 : 8'h03, bus.bus_address_in,
                             bus.bus_write ? bus.bus_data_in : 8'h00};
               cs_n_d     = 1'b0;
               bit_cnt_d  = 6'd32;
               div_cnt_d  = 8'd0;
               state_d    = StShift;
            end
         end
         StShift: begin
            if (div_cnt_q == DivLast) begin
               div_cnt_d = 8'd0;
               sck_d     = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[6:0], spi_miso};
               end else begin
                  tx_d      = {tx_q[30:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 6'd1;
                  if (bit_cnt_q == 6'd1) begin
                     state_d = StFinish;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         StFinish: begin
            cs_n_d = 1'b1;
            if (!op_write_q) begin
               rdata_d = rx_q;
            end
            done_d  = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            if (!req) begin
               done_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: two instances (CLK_DIV=2 and CLK_DIV=1), each with a behavioural SRAM.
// Expected SPI frames are queued per request and compared against frames the SRAM captures.
module tb_spi_mem_bridge;

   localparam int Div0 = 2;
   localparam int Div1 = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd [2];
   logic        wr [2];
   logic [15:0] addr [2];
   logic [7:0]  wd [2];
   logic        wait_w [2];
   logic [7:0]  dout_w [2];
   logic        sck0, cs_n0, mosi0, miso0;
   logic        sck1, cs_n1, mosi1, miso1;
   logic [39:0] sb_q [$];
   logic [7:0]  prog [5] = '{8'h06, 8'h42, 8'hC3, 8'h00, 8'h00};
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   spi_mem_bridge_if bus0 ();
   spi_mem_bridge_if bus1 ();

   assign bus0.bus_read       = rd[0];
   assign bus0.bus_write      = wr[0];
   assign bus0.bus_address_in = addr[0];
   assign bus0.bus_data_in    = wd[0];
   assign bus1.bus_read       = rd[1];
   assign bus1.bus_write      = wr[1];
   assign bus1.bus_address_in = addr[1];
   assign bus1.bus_data_in    = wd[1];
   assign wait_w[0]           = bus0.bus_wait;
   assign wait_w[1]           = bus1.bus_wait;
   assign dout_w[0]           = bus0.bus_data_out;
   assign dout_w[1]           = bus1.bus_data_out;

   spi_mem_bridge #(.CLK_DIV(Div0)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus0.slave),
      .spi_sck  (sck0),
      .spi_cs_n (cs_n0),
      .spi_mosi (mosi0),
      .spi_miso (miso0)
   );

   spi_mem_bridge #(.CLK_DIV(Div1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus1.slave),
      .spi_sck  (sck1),
      .spi_cs_n (cs_n1),
      .spi_mosi (mosi1),
      .spi_miso (miso1)
   );

   // Behavioural 23LC512: captures each frame as {sck rises, 32 MOSI bits}.
   for (genvar g = 0; g < 2; g++) begin : g_sram
      logic        sck_l, cs_n_l, mosi_l;
      logic        miso = 1'b0;
      logic [7:0]  mem [65536];
      logic [31:0] sh;
      logic [15:0] cur_addr;
      logic [7:0]  cmd_l;
      logic [39:0] obs_q [$];
      int          cnt = 0;
      int          rises = 0;

      assign sck_l  = (g == 0) ? sck0 : sck1;
      assign cs_n_l = (g == 0) ? cs_n0 : cs_n1;
      assign mosi_l = (g == 0) ? mosi0 : mosi1;

      initial begin
         for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
         mem[16'h1234] = 8'hA5;
         for (int i = 0; i < 5; i++) mem[i] = prog[i];
      end

      always @(negedge cs_n_l) begin
         cnt   = 0;
         rises = 0;
         sh    = '0;
         miso  = 1'b0;
      end

      always @(posedge sck_l) begin
         if (cs_n_l === 1'b0) begin
            sh = {sh[30:0], mosi_l};
            cnt++;
            rises++;
            if (cnt == 24) begin
               cur_addr = sh[15:0];
               cmd_l    = sh[23:16];
            end
         end
      end

      always @(negedge sck_l) begin
         if (cs_n_l === 1'b0 && cnt >= 24 && cnt < 32 && cmd_l == 8'h03)
            miso = mem[cur_addr][31-cnt];
      end

      always @(posedge cs_n_l) begin
         if (rst_n === 1'b1) begin
            obs_q.push_back({rises[7:0], sh});
            if (cnt == 32 && sh[31:24] == 8'h02) mem[sh[23:8]] = sh[7:0];
         end
      end
   end

   assign miso0 = g_sram[0].miso;
   assign miso1 = g_sram[1].miso;

   // One bus request; checks wait length, held read data and the SPI frame.
   task automatic bus_op(input int ln, input logic w, input logic r, input logic [15:0] a,
                         input logic [7:0] d, input int chg_at, input logic [15:0] a2,
                         input logic [7:0] exp_dout, input string name,
                         output logic [7:0] got);
      int          cyc;
      int          exp_wait;
      logic [39:0] exp_f;
      logic [39:0] obs_f;
      logic        have;
      exp_wait = 64 * ((ln == 0) ? Div0 : Div1) + 2;
      sb_q.push_back({8'd32, w ? 8'h02 : 8'h03, a, w ? d : 8'h00});
      @(posedge clk);
      #1;
      rd[ln] = r; wr[ln] = w; addr[ln] = a; wd[ln] = d;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!wait_w[ln] || cyc > 20000) break;
         cyc++;
         if (cyc == chg_at) addr[ln] = a2;
      end
      n_cmp++;
      if (cyc !== exp_wait) begin
         n_fail++;
         $display("FAIL %s wait_cycles: got %0d expected %0d", name, cyc, exp_wait);
      end
      @(posedge clk);
      #1;
      rd[ln] = 1'b0; wr[ln] = 1'b0;
      got = dout_w[ln];
      n_cmp++;
      if (got !== exp_dout) begin
         n_fail++;
         $display("FAIL %s data_out: got %h expected %h", name, got, exp_dout);
      end
      exp_f = sb_q.pop_front();
      have  = 1'b0;
      obs_f = '0;
      if (ln == 0 && g_sram[0].obs_q.size() > 0) begin
         obs_f = g_sram[0].obs_q.pop_front(); have = 1'b1;
      end else if (ln == 1 && g_sram[1].obs_q.size() > 0) begin
         obs_f = g_sram[1].obs_q.pop_front(); have = 1'b1;
      end
      n_cmp++;
      if (!have || obs_f !== exp_f) begin
         n_fail++;
         $display("FAIL %s spi_frame(rises,cmd,addr,data): got %h expected %h (frame seen %0d)",
                  name, obs_f, exp_f, have);
      end
   endtask

   task automatic test_reset();
      rd = '{1'b0, 1'b0}; wr = '{1'b0, 1'b0};
      addr = '{16'h0, 16'h0}; wd = '{8'h0, 8'h0};
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({sck0, cs_n0, mosi0, wait_w[0], sck1, cs_n1} !== 6'b010_001) begin
         n_fail++;
         $display("FAIL reset_pins: got %b expected 010001",
                  {sck0, cs_n0, mosi0, wait_w[0], sck1, cs_n1});
      end
      n_cmp++;
      if (dout_w[0] !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data_out: got %h expected 00", dout_w[0]);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_read();
      logic [7:0] got;
      int         bad;
      bus_op(0, 1'b0, 1'b1, 16'h1234, 8'h00, 0, 16'h0, 8'hA5, "read_1234", got);
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (dout_w[0] !== 8'hA5) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL read_hold: got %0d bad cycles expected 0 (last %h)", bad, dout_w[0]);
      end
   endtask

   task automatic test_write();
      logic [7:0] got;
      bus_op(0, 1'b1, 1'b0, 16'hBEEF, 8'h5A, 0, 16'h0, 8'hA5, "write_beef", got);
      bus_op(0, 1'b0, 1'b1, 16'hBEEF, 8'h00, 0, 16'h0, 8'h5A, "readback_beef", got);
   endtask

   task automatic test_addr_change();
      logic [7:0] got;
      bus_op(0, 1'b0, 1'b1, 16'h1234, 8'h00, 20, 16'hFFFF, 8'hA5, "addr_change", got);
   endtask

   task automatic test_cpu_fetch();
      logic [15:0] pc;
      logic [7:0]  op, lo, hi, exp;
      pc = 16'h0000;
      for (int n = 0; n < 2; n++) begin
         exp = (pc < 5) ? prog[pc[2:0]] : 8'h00;
         bus_op(1, 1'b0, 1'b1, pc, 8'h00, 0, 16'h0, exp, "fetch_op", op);
         if (op == 8'h06) begin
            bus_op(1, 1'b0, 1'b1, pc + 16'd1, 8'h00, 0, 16'h0, 8'h42, "fetch_imm", lo);
            pc = pc + 16'd2;
         end else if (op == 8'hC3) begin
            bus_op(1, 1'b0, 1'b1, pc + 16'd1, 8'h00, 0, 16'h0, 8'h00, "fetch_lo", lo);
            bus_op(1, 1'b0, 1'b1, pc + 16'd2, 8'h00, 0, 16'h0, 8'h00, "fetch_hi", hi);
            pc = {hi, lo};
         end else begin
            break;
         end
      end
      n_cmp++;
      if (pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL cpu_pc_loop: got %h expected 0000", pc);
      end
      bus_op(1, 1'b0, 1'b1, pc, 8'h00, 0, 16'h0, 8'h06, "fetch_again", op);
   endtask

   task automatic test_reset_mid();
      logic [7:0] got;
      int         k;
      @(posedge clk);
      #1;
      rd[0] = 1'b1; addr[0] = 16'h1234;
      k = 0;
      while (cs_n0 !== 1'b0 && k < 100) begin @(negedge clk); k++; end
      while (g_sram[0].rises < 10 && k < 5000) begin @(negedge clk); k++; end
      n_cmp++;
      if (k >= 5000) begin
         n_fail++;
         $display("FAIL reset_mid_reach_bit10: got timeout expected bit 10 reached");
      end
      rst_n = 1'b0;
      rd[0] = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cs_n0, sck0, wait_w[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_mid_pins(cs_n,sck,wait): got %b expected 100",
                  {cs_n0, sck0, wait_w[0]});
      end
      n_cmp++;
      if (dout_w[0] !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_data_out: got %h expected 00", dout_w[0]);
      end
      rst_n = 1'b1;
      g_sram[0].obs_q.delete();
      repeat (2) @(posedge clk);
      bus_op(0, 1'b0, 1'b1, 16'hBEEF, 8'h00, 0, 16'h0, 8'h5A, "after_reset_read", got);
   endtask

   task automatic test_both_req();
      logic [7:0] got;
      bus_op(0, 1'b1, 1'b1, 16'h0100, 8'h77, 0, 16'h0, 8'h5A, "both_req_write", got);
      bus_op(0, 1'b0, 1'b1, 16'h0100, 8'h00, 0, 16'h0, 8'h77, "both_req_readback", got);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_addr_change();
      test_cpu_fetch();
      test_reset_mid();
      test_both_req();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
- Sits directly downstream of the cpu core's memory bus.
- Turns each single-byte bus read or write into one SPI-mode-0 transaction to an external 23LC512-style SPI SRAM (16-bit address).
- Holds bus_wait high until the transaction finishes.
- Keeps the read byte stable on bus_data_out until the next read, because the core consumes read data one or more cycles after wait drops.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles; legal range 1..255.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
bus_address_in  in  16  byte address from core
bus_data_in  in  8  write data from core
bus_data_out  out  8  read data to core; held until next read completes
bus_read  in  1  read request level, held by core until it sees wait low
bus_write  in  1  write request level, same rules as bus_read
bus_wait  out  1  combinational; high while an accepted request is outstanding
spi_sck  out  1  SPI clock, idle low
spi_cs_n  out  1  chip select, idle high
spi_mosi  out  1  serial data to memory, MSB first
spi_miso  in  1  serial data from memory

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - Reset values: state=IDLE, done=0, spi_sck=0, spi_cs_n=1, spi_mosi=0, bus_data_out=8'h00, shift/rx/counters=0.
  - Reset mid-transaction aborts on the next edge: cs_n=1, sck=0, no data update.
- Request: req = bus_read | bus_write.
  - bus_wait = req & ~done. Because it is combinational, wait is high in the very first cycle a request appears.
- States: IDLE, SHIFT, FINISH, DONE.
- IDLE with req=1 (done=0 guaranteed):
  - Latch op_write = bus_write. Write has priority if both requests are high.
  - Load tx shift reg = {cmd, bus_address_in, wdata}, where cmd=8'h02/wdata=bus_data_in for a write, and cmd=8'h03/wdata=8'h00 for a read.
  - Set cs_n=0, bit_cnt=32, div_cnt=0; go to SHIFT.
- SHIFT: spi_mosi = tx[31] at all times while in SHIFT.
  - div_cnt counts 0..CLK_DIV-1; on terminal count, toggle sck and clear div_cnt.
  - Toggle 0->1: shift spi_miso into 8-bit rx (rx <= {rx[6:0], spi_miso}).
  - Toggle 1->0: tx <= tx<<1, bit_cnt--. When bit_cnt reaches 0 on this edge, go to FINISH. sck is already 0.
- FINISH (1 cycle): cs_n<=1; if read, bus_data_out<=rx; done<=1; go to DONE.
- DONE: wait is low. When req=0, done<=0 and go to IDLE. A new request requires at least one req-low cycle; the core always provides one.
- Bus inputs are ignored after the IDLE latch cycle. Address or data changes mid-transfer have no effect.
- Writes never modify bus_data_out. spi_miso is sampled but discarded.
- Latency: bus_wait is high for exactly 64*CLK_DIV+2 consecutive cycles per request (130 at default). The data phase is the last 8 SCK rising edges.
- SCK frequency = clk/(2*CLK_DIV).
- cs_n falls at least CLK_DIV cycles before the first SCK rise, and rises 1 cycle after the last SCK fall.

Test Plan:
1. Read 0x1234, SRAM model returns 0xA5 -> MOSI bytes 03 12 34 00, bus_wait high 130 cycles, bus_data_out=0xA5, stays 0xA5 ≥10 cycles after req drops.
2. Write 0x5A to 0xBEEF -> MOSI bytes 02 BE EF 5A, exactly 32 SCK rises, cs_n low throughout, bus_data_out keeps previous 0xA5; a later read of 0xBEEF returns 0x5A.
3. CLK_DIV=1, cpu core driven by program 06 42 (LD B,0x42) then C3 00 00 (JP 0x0000) -> reads at 0000,0001,0002,0003,0004, each with wait high 66 cycles; PC loops to 0000.
4. Change bus_address_in 0x1234->0xFFFF 20 cycles into a read -> MOSI address still 12 34.
5. Assert rst_n=0 mid-SHIFT (bit 10) -> next edge cs_n=1, sck=0, bus_wait=0 (done=0 with no req after reset), bus_data_out=0x00. A subsequent read completes normally.
6. Both bus_read and bus_write high, data 0x77 -> write command 02 issued, bus_data_out unchanged.
